// File: rtl/dma_word_copier_pkg.sv
// Shared types and constants for the word-copy DMA engine.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    FINISH
  } dma_state_t;

  localparam logic [1:0]  BYTESEL_WORD = 2'b11;
  localparam int unsigned ADDR_W       = 19;
  localparam int unsigned DATA_W       = 16;

endpackage

// File: rtl/dma_word_copier_fifo.sv
// Burst-deep word buffer between the read and write phases.
module dma_word_fifo
  import dma_pkg::*;
#(
  parameter int unsigned burst = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [DATA_W-1:0]          i_wr_data,
  output logic [DATA_W-1:0]          o_rd_data,
  output logic [DATA_W-1:0]          o_rd_next,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(burst):0]     o_level
);

  localparam int unsigned IW = $clog2(burst);
  localparam int unsigned CW = IW + 1;

  logic [DATA_W-1:0] r_mem [burst];
  logic [IW-1:0]     r_rd_idx;
  logic [IW-1:0]     r_wr_idx;
  logic [CW-1:0]     r_level;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign o_full    = (r_level == CW'(burst));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;
  assign o_rd_data = r_mem[r_rd_idx];
  // Word behind the head, so the writer can preload it on the pop edge.
  assign o_rd_next = r_mem[r_rd_idx + IW'(1)];

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_idx] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_idx <= '0;
      r_wr_idx <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_idx <= r_wr_idx + IW'(1);
      if (w_pop_ok)  r_rd_idx <= r_rd_idx + IW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + CW'(1);
        2'b01:   r_level <= r_level - CW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/dma_word_copier.sv
// Word-copy bus initiator: reads a burst into a buffer, writes it out, repeats.
module dma_word_copier
  import dma_pkg::*;
#(
  parameter int unsigned burst     = 8,
  parameter int unsigned len_width = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    src_addr,
  input  logic [ADDR_W-1:0]    dst_addr,
  input  logic [len_width-1:0] count,
  output logic                 busy,
  output logic                 done,
  output logic                 data_m_access,
  input  logic                 data_m_ack,
  output logic [ADDR_W-1:0]    data_m_addr,
  output logic                 data_m_wr_en,
  output logic [DATA_W-1:0]    data_m_data_out,
  input  logic [DATA_W-1:0]    data_m_data_in,
  output logic [1:0]           data_m_bytesel
);

  localparam int unsigned          LVL_W   = $clog2(burst) + 1;
  localparam logic [len_width-1:0] LEN_ONE = len_width'(1);

  dma_state_t            r_state, w_state_nxt;
  logic                  r_req;
  logic                  r_wr_en;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_data_out;
  logic [ADDR_W-1:0]     r_rd_ptr;
  logic [ADDR_W-1:0]     r_wr_ptr;
  logic [len_width-1:0]  r_rd_left;
  logic [len_width-1:0]  r_wr_left;

  logic                  w_ack;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_W-1:0]     w_fifo_rd_data;
  logic [DATA_W-1:0]     w_fifo_rd_next;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [LVL_W-1:0]      w_fifo_level;
  logic                  w_rd_last;
  logic                  w_wr_last;
  logic [DATA_W-1:0]     w_head;

  // Only an ack against an outstanding request counts.
  assign w_ack     = data_m_ack & r_req;
  assign w_push    = (r_state == READ) & w_ack & ~w_fifo_full;
  assign w_pop     = (r_state == WRITE) & w_ack;
  assign w_rd_last = (w_fifo_level == LVL_W'(burst - 1)) | (r_rd_left == LEN_ONE);
  assign w_wr_last = (w_fifo_level == LVL_W'(1));
  // On a single-word burst the head is the word arriving this cycle.
  assign w_head    = w_fifo_empty ? data_m_data_in : w_fifo_rd_data;

  assign data_m_access   = r_req & ~data_m_ack;
  assign data_m_addr     = r_addr;
  assign data_m_wr_en    = r_wr_en;
  assign data_m_data_out = r_data_out;
  assign data_m_bytesel  = BYTESEL_WORD;

  dma_word_fifo #(.burst(burst)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_wr_data (data_m_data_in),
    .o_rd_data (w_fifo_rd_data),
    .o_rd_next (w_fifo_rd_next),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_level   (w_fifo_level)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   if (start) w_state_nxt = (count != '0) ? READ : FINISH;
      READ:   if (w_ack && w_rd_last) w_state_nxt = WRITE;
      WRITE:  if (w_ack && w_wr_last) w_state_nxt = (r_wr_left == LEN_ONE) ? FINISH : READ;
      FINISH: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == READ) || (r_state == WRITE);
    done = (r_state == FINISH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req      <= 1'b0;
      r_wr_en    <= 1'b0;
      r_addr     <= '0;
      r_data_out <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_rd_left  <= '0;
      r_wr_left  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start && count != '0) begin
            r_req     <= 1'b1;
            r_wr_en   <= 1'b0;
            r_addr    <= src_addr;
            r_rd_ptr  <= src_addr;
            r_wr_ptr  <= dst_addr;
            r_rd_left <= count;
            r_wr_left <= count;
          end
        end
        READ: begin
          if (w_ack) begin
            r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
            r_rd_left <= r_rd_left - LEN_ONE;
            if (w_rd_last) begin
              r_wr_en    <= 1'b1;
              r_addr     <= r_wr_ptr;
              r_data_out <= w_head;
            end else begin
              r_addr <= r_rd_ptr + ADDR_W'(1);
            end
          end
        end
        WRITE: begin
          if (w_ack) begin
            r_wr_ptr  <= r_wr_ptr + ADDR_W'(1);
            r_wr_left <= r_wr_left - LEN_ONE;
            if (w_wr_last) begin
              r_wr_en <= 1'b0;
              if (r_wr_left == LEN_ONE) r_req  <= 1'b0;
              else                      r_addr <= r_rd_ptr;
            end else begin
              r_addr     <= r_wr_ptr + ADDR_W'(1);
              r_data_out <= w_fifo_rd_next;
            end
          end
        end
        FINISH: r_req <= 1'b0;
        default: r_req <= 1'b0;
      endcase
    end
  end

endmodule
